// File: rtl/stopwatch_dp_if.sv
// Signal bundle between the stopwatch control FSM (master) and the stopwatch datapath (slave).
// The i_btn_lap signal exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_dp_if;
    logic       i_run;
    logic       i_clear;
`ifdef STOPWATCH_LAP_EN
    logic       i_btn_lap;
`endif
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;

`ifdef STOPWATCH_LAP_EN
    modport master (
        output i_run, i_clear, i_btn_lap,
        input  o_msec, o_sec, o_min, o_hour, o_tick
    );
    modport slave (
        input  i_run, i_clear, i_btn_lap,
        output o_msec, o_sec, o_min, o_hour, o_tick
    );
`else
    modport master (
        output i_run, i_clear,
        input  o_msec, o_sec, o_min, o_hour, o_tick
    );
    modport slave (
        input  i_run, i_clear,
        output o_msec, o_sec, o_min, o_hour, o_tick
    );
`endif
endinterface

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: pausable clock divider producing a TICK_HZ time base feeding an
// hh:mm:ss.cc counter chain. Optional lap freeze of the display via STOPWATCH_LAP_EN.
module stopwatch_dp #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input logic           clk,
    input logic           reset,
    stopwatch_dp_if.slave sw
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [6:0]       msec_reg, msec_next;
    logic [5:0]       sec_reg, sec_next;
    logic [5:0]       min_reg, min_next;
    logic [4:0]       hour_reg, hour_next;
    logic             tick_reg;
    logic             tick;
    logic             msec_wrap, sec_wrap, min_wrap, hour_wrap;

    // Divider holds its phase while paused so a resume continues the partial period.
    always_comb begin
        tick         = sw.i_run & ~sw.i_clear & (div_cnt_reg == DIV_LAST);
        div_cnt_next = div_cnt_reg;
        if (sw.i_clear) begin
            div_cnt_next = '0;
        end else if (sw.i_run) begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_next = '0;
            end else begin
                div_cnt_next = div_cnt_reg + 1'b1;
            end
        end
    end

    // Full carry chain resolves combinationally so every rollover lands on a single edge.
    always_comb begin
        msec_wrap = (msec_reg == 7'd99);
        sec_wrap  = (sec_reg  == 6'd59);
        min_wrap  = (min_reg  == 6'd59);
        hour_wrap = (hour_reg == 5'd23);
        msec_next = msec_reg;
        sec_next  = sec_reg;
        min_next  = min_reg;
        hour_next = hour_reg;
        if (sw.i_clear) begin
            msec_next = '0;
            sec_next  = '0;
            min_next  = '0;
            hour_next = '0;
        end else if (tick) begin
            msec_next = msec_wrap ? 7'd0 : msec_reg + 7'd1;
            if (msec_wrap) begin
                sec_next = sec_wrap ? 6'd0 : sec_reg + 6'd1;
                if (sec_wrap) begin
                    min_next = min_wrap ? 6'd0 : min_reg + 6'd1;
                    if (min_wrap) begin
                        hour_next = hour_wrap ? 5'd0 : hour_reg + 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
            msec_reg    <= '0;
            sec_reg     <= '0;
            min_reg     <= '0;
            hour_reg    <= '0;
            tick_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            msec_reg    <= msec_next;
            sec_reg     <= sec_next;
            min_reg     <= min_next;
            hour_reg    <= hour_next;
            tick_reg    <= tick;
        end
    end

    assign sw.o_tick = tick_reg;

`ifdef STOPWATCH_LAP_EN
    logic       lap_hold_reg, lap_hold_next;
    logic [6:0] snap_msec_reg, snap_msec_next;
    logic [5:0] snap_sec_reg, snap_sec_next;
    logic [5:0] snap_min_reg, snap_min_next;
    logic [4:0] snap_hour_reg, snap_hour_next;
    logic [6:0] disp_msec_reg;
    logic [5:0] disp_sec_reg;
    logic [5:0] disp_min_reg;
    logic [4:0] disp_hour_reg;

    // Snapshot takes the values currently on display (pre-tick), matching what the user saw.
    always_comb begin
        lap_hold_next  = lap_hold_reg;
        snap_msec_next = snap_msec_reg;
        snap_sec_next  = snap_sec_reg;
        snap_min_next  = snap_min_reg;
        snap_hour_next = snap_hour_reg;
        if (sw.i_clear) begin
            lap_hold_next  = 1'b0;
            snap_msec_next = '0;
            snap_sec_next  = '0;
            snap_min_next  = '0;
            snap_hour_next = '0;
        end else if (sw.i_btn_lap) begin
            if (lap_hold_reg) begin
                lap_hold_next = 1'b0;
            end else if (sw.i_run) begin
                lap_hold_next  = 1'b1;
                snap_msec_next = msec_reg;
                snap_sec_next  = sec_reg;
                snap_min_next  = min_reg;
                snap_hour_next = hour_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold_reg  <= 1'b0;
            snap_msec_reg <= '0;
            snap_sec_reg  <= '0;
            snap_min_reg  <= '0;
            snap_hour_reg <= '0;
            disp_msec_reg <= '0;
            disp_sec_reg  <= '0;
            disp_min_reg  <= '0;
            disp_hour_reg <= '0;
        end else begin
            lap_hold_reg  <= lap_hold_next;
            snap_msec_reg <= snap_msec_next;
            snap_sec_reg  <= snap_sec_next;
            snap_min_reg  <= snap_min_next;
            snap_hour_reg <= snap_hour_next;
            disp_msec_reg <= lap_hold_next ? snap_msec_next : msec_next;
            disp_sec_reg  <= lap_hold_next ? snap_sec_next  : sec_next;
            disp_min_reg  <= lap_hold_next ? snap_min_next  : min_next;
            disp_hour_reg <= lap_hold_next ? snap_hour_next : hour_next;
        end
    end

    assign sw.o_msec = disp_msec_reg;
    assign sw.o_sec  = disp_sec_reg;
    assign sw.o_min  = disp_min_reg;
    assign sw.o_hour = disp_hour_reg;
`else
    assign sw.o_msec = msec_reg;
    assign sw.o_sec  = sec_reg;
    assign sw.o_min  = min_reg;
    assign sw.o_hour = hour_reg;
`endif
endmodule

// File: tb/tb_stopwatch_dp.sv
// Self-checking bench for stopwatch_dp (DIV=10). Reference model tracks elapsed run cycles
// and derives the displayed time arithmetically; lap checks are built with STOPWATCH_LAP_EN.
module tb_stopwatch_dp;
    localparam int    DIV    = 10;
    localparam longint DAY_CS = 64'd8640000;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    stopwatch_dp_if sw ();

    stopwatch_dp #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    longint run_cycles;
    longint offset;
    bit     m_tick;
`ifdef STOPWATCH_LAP_EN
    bit     lap_pulse;
    bit     m_hold;
    longint m_snap;
`endif

    function automatic longint cur_ticks();
        return (run_cycles / DIV + offset) % DAY_CS;
    endfunction

    function automatic logic [24:0] exp_vec();
        longint d;
        d = cur_ticks();
`ifdef STOPWATCH_LAP_EN
        if (m_hold) d = m_snap;
`endif
        return {5'((d / 360000) % 24), 6'((d / 6000) % 60), 6'((d / 100) % 60),
                7'(d % 100), m_tick};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {sw.o_hour, sw.o_min, sw.o_sec, sw.o_msec, sw.o_tick};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        run_cycles = 0;
        offset     = 0;
        m_tick     = 1'b0;
`ifdef STOPWATCH_LAP_EN
        m_hold     = 1'b0;
        m_snap     = 0;
`endif
    endtask

    // Called at a negedge: drive inputs, advance model, clock once, compare at next negedge.
    task automatic cycle(input bit r, input bit c);
        sw.i_run   = r;
        sw.i_clear = c;
`ifdef STOPWATCH_LAP_EN
        sw.i_btn_lap = lap_pulse;
`endif
        if (c) begin
            model_reset();
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (lap_pulse) begin
                if (m_hold) m_hold = 1'b0;
                else if (r) begin
                    m_hold = 1'b1;
                    m_snap = cur_ticks();
                end
            end
`endif
            if (r) run_cycles++;
            m_tick = r && (run_cycles % DIV == 0);
        end
        @(posedge clk);
        @(negedge clk);
        check("cycle_outputs", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    // Loads the counter registers directly to reach late-day states within the cycle budget.
    task automatic preload(input longint t);
        force dut.msec_reg = 7'(t % 100);
        force dut.sec_reg  = 6'((t / 100) % 60);
        force dut.min_reg  = 6'((t / 6000) % 60);
        force dut.hour_reg = 5'((t / 360000) % 24);
        #1;
        release dut.msec_reg;
        release dut.sec_reg;
        release dut.min_reg;
        release dut.hour_reg;
        offset = t - run_cycles / DIV;
    endtask

    initial begin
        int ticks_seen;
        int first_tick;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        sw.i_run   = 1'b0;
        sw.i_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_pulse    = 1'b0;
        sw.i_btn_lap = 1'b0;
`endif
        model_reset();
        #3;
        check("reset_state", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic run: 25 cycles gives two ticks
        ticks_seen = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, 1'b0);
            if (sw.o_tick) ticks_seen++;
        end
        check("run25_msec", 32'(sw.o_msec), 32'd2);
        check("run25_ticks", 32'(ticks_seen), 32'd2);
        check("run25_upper", 32'({sw.o_hour, sw.o_min, sw.o_sec}), 32'd0);

        // Pause/resume keeps the partial period
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        check("pause_pre_msec", 32'(sw.o_msec), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0);
            check("pause_hold_msec", 32'(sw.o_msec), 32'd1);
        end
        first_tick = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0);
            if (sw.o_tick && first_tick < 0) first_tick = i;
        end
        check("resume_tick_delay", 32'(first_tick), 32'd10);

        // Full carry 00:59:59.99 -> 01:00:00.00
        cycle(1'b0, 1'b1);
        preload(64'd359999);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0);
        check("carry_pre", 32'({sw.o_hour, sw.o_min, sw.o_sec, sw.o_msec}),
              32'({5'd0, 6'd59, 6'd59, 7'd99}));
        cycle(1'b1, 1'b0);
        check("carry_hour", 32'({sw.o_hour, sw.o_min, sw.o_sec, sw.o_msec, sw.o_tick}),
              32'({5'd1, 6'd0, 6'd0, 7'd0, 1'b1}));

        // Day wrap 23:59:59.99 -> 00:00:00.00
        cycle(1'b0, 1'b1);
        preload(64'd8639999);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        check("day_wrap", 32'({sw.o_hour, sw.o_min, sw.o_sec, sw.o_msec, sw.o_tick}),
              32'({5'd0, 6'd0, 6'd0, 7'd0, 1'b1}));

        // Clear on the tick edge suppresses the tick
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 429; i++) cycle(1'b1, 1'b0);
        check("clr_pre_msec", 32'(sw.o_msec), 32'd42);
        cycle(1'b1, 1'b1);
        check("clr_on_tick", 32'(dut_vec()), 32'd0);
        first_tick = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 1'b0);
            if (sw.o_tick && first_tick < 0) first_tick = i;
        end
        check("clr_next_tick", 32'(first_tick), 32'd10);

        // Asynchronous reset mid-count
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3005; i++) cycle(1'b1, 1'b0);
        check("areset_pre_sec", 32'(sw.o_sec), 32'd3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("areset_async", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        first_tick = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 1'b0);
            if (sw.o_tick && first_tick < 0) first_tick = i;
        end
        check("areset_next_tick", 32'(first_tick), 32'd10);

`ifdef STOPWATCH_LAP_EN
        // Lap freeze and release
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0);
        check("lap_pre_msec", 32'(sw.o_msec), 32'd5);
        lap_pulse = 1'b1;
        cycle(1'b1, 1'b0);
        lap_pulse = 1'b0;
        for (int i = 0; i < 29; i++) cycle(1'b1, 1'b0);
        check("lap_frozen", 32'(sw.o_msec), 32'd5);
        lap_pulse = 1'b1;
        cycle(1'b1, 1'b0);
        lap_pulse = 1'b0;
        check("lap_release", 32'(sw.o_msec), 32'd8);
        lap_pulse = 1'b1;
        cycle(1'b0, 1'b0);
        lap_pulse = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        check("lap_idle_ignored", 32'(sw.o_msec), 32'd9);
`endif

        // Randomized run/pause/clear traffic against the model
        for (int i = 0; i < 400; i++) begin
`ifdef STOPWATCH_LAP_EN
            lap_pulse = ($urandom_range(0, 19) == 0);
`endif
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
        end
`ifdef STOPWATCH_LAP_EN
        lap_pulse = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
